// File: rtl/if_sequencer.sv
// Fetch-stage controller: owns instruction memory, loads a program in IDLE,
// then streams it to decode over valid/ready with branch redirection and wrong-path flush.
module if_sequencer #(
  parameter int INST_CAP = 5,
  parameter int INST_LEN = 17,
  parameter int PC_W     = $clog2(INST_CAP) + 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                load_valid,
  input  logic [INST_LEN-1:0] load_data,
  output logic                load_ready,
  input  logic                start,
  input  logic                clear,
  input  logic                branch_valid,
  input  logic [PC_W-1:0]     branch_target,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [PC_W-1:0]     inst_pc,
  output logic                busy,
  output logic                done
);

  // Handshakes: a word moves on a rising edge when valid && ready are both high;
  // the producer holds data stable while valid && !ready.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int            AW  = (INST_CAP > 1) ? $clog2(INST_CAP) : 1;
  localparam logic [PC_W-1:0] CAP = PC_W'(INST_CAP);
  localparam logic [PC_W-1:0] ONE = PC_W'(1);

  logic [INST_LEN-1:0] mem_q [INST_CAP];

  logic [1:0]          state_q, state_d;
  logic [PC_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     prog_len_q, prog_len_d;
  logic [PC_W-1:0]     inst_pc_q, inst_pc_d;
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic                inst_valid_q, inst_valid_d;
  logic                load_fire;
  logic                slot_free;

  assign load_ready = rstn && (state_q == S_IDLE) && (wr_ptr_q < CAP);
  assign load_fire  = load_valid && load_ready;
  assign slot_free  = !inst_valid_q || inst_ready;

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (load_fire) mem_q[wr_ptr_q[AW-1:0]] <= load_data;
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    pc_d         = pc_q;
    prog_len_d   = prog_len_q;
    inst_pc_d    = inst_pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    case (state_q)
      S_IDLE: begin
        if (load_fire) wr_ptr_d = wr_ptr_q + ONE;
        // A word accepted alongside start belongs to the program being launched.
        if (start && (wr_ptr_d != '0)) begin
          prog_len_d = wr_ptr_d;
          pc_d       = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (branch_valid) begin
          inst_valid_d = 1'b0;
          // Out-of-program targets park pc at prog_len so the next free slot ends the run.
          pc_d = (branch_target >= prog_len_q) ? prog_len_q : branch_target;
        end else if (slot_free) begin
          if (pc_q < prog_len_q) begin
            inst_d       = mem_q[pc_q[AW-1:0]];
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + ONE;
          end else begin
            inst_valid_d = 1'b0;
            state_d      = S_DONE;
          end
        end
      end
      S_DONE: begin
        inst_valid_d = 1'b0;
        if (start) begin
          pc_d    = '0;
          state_d = S_RUN;
        end else if (clear) begin
          wr_ptr_d   = '0;
          prog_len_d = '0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        inst_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      pc_q         <= '0;
      prog_len_q   <= '0;
      inst_pc_q    <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pc_q         <= pc_d;
      prog_len_q   <= prog_len_d;
      inst_pc_q    <= inst_pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

endmodule

// File: tb/tb_if_sequencer.sv
// Directed bench for if_sequencer: a program-level model predicts the accepted
// instruction stream, checked at every handshake, plus hand-computed timing points.
module tb_if_sequencer;
  localparam int INST_CAP = 5;
  localparam int INST_LEN = 17;
  localparam int PC_W     = $clog2(INST_CAP) + 1;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                load_valid = 1'b0;
  logic [INST_LEN-1:0] load_data = '0;
  logic                start = 1'b0;
  logic                clear = 1'b0;
  logic                branch_valid = 1'b0;
  logic [PC_W-1:0]     branch_target = '0;
  logic                inst_ready = 1'b1;
  logic                load_ready;
  logic                inst_valid;
  logic [INST_LEN-1:0] inst;
  logic [PC_W-1:0]     inst_pc;
  logic                busy;
  logic                done;

  int n_cmp = 0;
  int n_err = 0;

  logic [PC_W+INST_LEN-1:0] exp_q[$];
  logic [INST_LEN-1:0]      model_mem[INST_CAP];
  int                       model_wr = 0;

  if_sequencer #(.INST_CAP(INST_CAP), .INST_LEN(INST_LEN), .PC_W(PC_W)) dut (
    .clk(clk), .rstn(rstn),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .start(start), .clear(clear),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [INST_LEN-1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    if (model_wr < INST_CAP) begin
      model_mem[model_wr] = d;
      model_wr++;
    end
    tick();
    load_valid = 1'b0;
  endtask

  task automatic push_run(input int first, input int last);
    for (int p = first; p <= last; p++) exp_q.push_back({PC_W'(p), model_mem[p]});
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_wr = 0;
  endtask

  task automatic wait_done(input string name, input int exp_ticks, input int exp_valid);
    int t;
    int v;
    t = 0;
    v = 0;
    while (!done && t < 40) begin
      tick();
      t++;
      if (inst_valid) v++;
    end
    check({name, "_cycles_to_done"}, 32'(t), 32'(exp_ticks));
    check({name, "_valid_cycles"}, 32'(v), 32'(exp_valid));
    check({name, "_valid_at_done"}, 32'(inst_valid), 32'd0);
    check({name, "_exp_q_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every accepted instruction must be the next one the model predicts.
  always @(negedge clk) begin
    logic [PC_W+INST_LEN-1:0] e;
    if (rstn) begin
      if (inst_valid && inst_ready && !branch_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_inst: got pc %0d inst 0x%0h, required no instruction", inst_pc, inst);
        end else begin
          e = exp_q.pop_front();
          check("sb_inst_pc", 32'(inst_pc), 32'(e[PC_W+INST_LEN-1:INST_LEN]));
          check("sb_inst", 32'(inst), 32'(e[INST_LEN-1:0]));
        end
      end
      if (inst_valid) check("valid_only_in_run", 32'(busy), 32'd1);
    end
  end

  initial begin
    logic [INST_LEN-1:0] br_prog[5];
    br_prog[0] = 17'h10010;
    br_prog[1] = 17'h00220;
    br_prog[2] = 17'h13330;
    br_prog[3] = 17'h04440;
    br_prog[4] = 17'h15550;

    // Reset
    #12;
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    rstn = 1'b1;
    #1;
    check("rel_load_ready", 32'(load_ready), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);
    check("rel_done", 32'(done), 32'd0);
    check("rel_inst_pc", 32'(inst_pc), 32'd0);

    // Fill memory, overfill refused, full-speed run
    for (int i = 1; i <= 5; i++) load_word(INST_LEN'(i));
    load_valid = 1'b1;
    load_data  = 17'h00006;
    check("full_load_ready", 32'(load_ready), 32'd0);
    tick();
    tick();
    check("full_load_ready_held", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    push_run(0, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_latency_no_valid", 32'(inst_valid), 32'd0);
    tick();
    check("first_valid", 32'(inst_valid), 32'd1);
    check("first_inst", 32'(inst), 32'h00001);
    check("first_pc", 32'(inst_pc), 32'd0);
    wait_done("run5", 5, 4);
    check("run5_done", 32'(done), 32'd1);

    // Re-run from DONE
    push_run(0, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("rerun", 6, 5);

    // Backpressure on a 3-word program
    do_clear();
    check("clear_load_ready", 32'(load_ready), 32'd1);
    check("clear_done", 32'(done), 32'd0);
    load_word(17'h1A0A0);
    load_word(17'h0BEEF);
    load_word(17'h1FFFF);
    push_run(0, 2);
    inst_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", 32'(inst_valid), 32'd1);
      check("stall_pc", 32'(inst_pc), 32'd0);
      check("stall_inst", 32'(inst), 32'h1A0A0);
      tick();
    end
    inst_ready = 1'b1;
    wait_done("stall_run", 3, 2);

    // Branch to pc 3 while pc 1 is presented
    do_clear();
    for (int i = 0; i < 5; i++) load_word(br_prog[i]);
    push_run(0, 0);
    push_run(3, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("br_pre_valid", 32'(inst_valid), 32'd1);
    check("br_pre_pc", 32'(inst_pc), 32'd1);
    branch_valid  = 1'b1;
    branch_target = PC_W'(3);
    tick();
    branch_valid = 1'b0;
    check("br_bubble", 32'(inst_valid), 32'd0);
    check("br_bubble_busy", 32'(busy), 32'd1);
    tick();
    check("br_target_valid", 32'(inst_valid), 32'd1);
    check("br_target_pc", 32'(inst_pc), 32'd3);
    check("br_target_inst", 32'(inst), 32'h04440);
    wait_done("br_run", 2, 1);

    // Branch past program end: flush and finish without further output
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("br7_pc0_valid", 32'(inst_valid), 32'd1);
    branch_valid  = 1'b1;
    branch_target = PC_W'(7);
    tick();
    branch_valid = 1'b0;
    check("br7_bubble", 32'(inst_valid), 32'd0);
    check("br7_not_done_yet", 32'(done), 32'd0);
    tick();
    check("br7_done", 32'(done), 32'd1);
    check("br7_no_valid", 32'(inst_valid), 32'd0);
    tick();
    tick();
    check("br7_exp_q_drained", 32'(exp_q.size()), 32'd0);

    // Start with empty memory is ignored; start with a concurrent load runs one word
    do_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_start_busy", 32'(busy), 32'd0);
    check("empty_start_load_ready", 32'(load_ready), 32'd1);
    tick();
    check("empty_start_done", 32'(done), 32'd0);
    load_valid = 1'b1;
    load_data  = 17'h0ABCD;
    start      = 1'b1;
    model_mem[0] = 17'h0ABCD;
    model_wr = 1;
    push_run(0, 0);
    tick();
    load_valid = 1'b0;
    start      = 1'b0;
    check("ld_start_busy", 32'(busy), 32'd1);
    wait_done("ld_start_run", 2, 1);

    // Asynchronous reset in the middle of a run
    do_clear();
    for (int i = 0; i < 5; i++) load_word(INST_LEN'(17'h00100 + i));
    push_run(0, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_pc", 32'(inst_pc), 32'd2);
    rstn = 1'b0;
    #1;
    check("rst_mid_valid", 32'(inst_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_inst_pc", 32'(inst_pc), 32'd0);
    check("rst_mid_load_ready", 32'(load_ready), 32'd0);
    tick();
    rstn = 1'b1;
    model_wr = 0;
    #1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("post_rst_start_ignored", 32'(busy), 32'd0);
    check("post_rst_load_ready", 32'(load_ready), 32'd1);
    tick();
    check("post_rst_exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
